// File: rtl/mips_cpu_mem_pkg.sv
// Shared types for the CPU memory arbiter: FSM states, grant
// encoding and the data word returned on a bus timeout.
package mips_cpu_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_grant_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mips_cpu_rr_pick.sv
// Two-way round-robin pick between instruction and data requesters.
// Ports: req_i/req_d requests, last_grant history, grant choice.
module mips_cpu_rr_pick
    import mips_cpu_mem_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  arb_grant_t last_grant,
    output arb_grant_t grant
);

    always_comb begin
        grant = GNT_I;
        unique case (1'b1)
            req_i && req_d:
                grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
            !req_i && req_d:
                grant = GNT_D;
            default:
                grant = GNT_I;
        endcase
    end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Ports: i_* fetch side, d_* data side, mem_* registered memory
// side, bus_error sticky timeout flag; clk / async reset_n.
module mips_cpu_mem_arbiter
    import mips_cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_waitrequest,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_waitrequest,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                mem_waitrequest,
    output logic                bus_error
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT > 0);

    arb_state_t          state_q;
    arb_grant_t          grant_q;
    arb_grant_t          last_q;
    arb_grant_t          pick;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                err_q;
    logic                req_i;
    logic                req_d;
    logic                to_hit;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    mips_cpu_rr_pick u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_q),
        .grant      (pick)
    );

    assign cnt_d  = cnt_q + CNT_W'(1);
    // This stall cycle is the TIMEOUT-th one: abort at this edge.
    assign to_hit = TO_EN && mem_waitrequest && (cnt_d == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= GNT_I;
            last_q    <= GNT_D;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (req_i || req_d) begin
                        grant_q <= pick;
                        cnt_q   <= '0;
                        state_q <= ARB_ACCESS;
                        if (pick == GNT_I) begin
                            addr_q <= i_address;
                            rd_q   <= 1'b1;
                            wr_q   <= 1'b0;
                            be_q   <= '1;
                        end else begin
                            // Write wins when both data strobes are high.
                            addr_q  <= d_address;
                            rd_q    <= ~d_write;
                            wr_q    <= d_write;
                            wdata_q <= d_writedata;
                            be_q    <= d_byteenable;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (!mem_waitrequest) begin
                        if (rd_q) begin
                            if (grant_q == GNT_I) begin
                                i_rdata_q <= mem_readdata;
                            end else begin
                                d_rdata_q <= mem_readdata;
                            end
                        end
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        last_q  <= grant_q;
                        state_q <= ARB_RESP;
                    end else if (to_hit) begin
                        if (grant_q == GNT_I) begin
                            i_rdata_q <= DATA_W'(BUS_ERR_DATA);
                        end else begin
                            d_rdata_q <= DATA_W'(BUS_ERR_DATA);
                        end
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        err_q   <= 1'b1;
                        last_q  <= grant_q;
                        state_q <= ARB_RESP;
                    end else if (TO_EN) begin
                        cnt_q <= cnt_d;
                    end
                end
                ARB_RESP: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign i_waitrequest  = !((state_q == ARB_RESP) && (grant_q == GNT_I));
    assign d_waitrequest  = !((state_q == ARB_RESP) && (grant_q == GNT_D));
    assign i_readdata     = i_rdata_q;
    assign d_readdata     = d_rdata_q;
    assign mem_address    = addr_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = wdata_q;
    assign mem_byteenable = be_q;
    assign bus_error      = err_q;

    a_rw_excl: assert property (
        @(posedge clk) disable iff (!reset_n) !(d_read && d_write)
    );

endmodule
